// File: rtl/wb_interconnect_pipelined_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_interconnect_pipelined_if
// Description : Bus bundle for the pipelined Wishbone interconnect. It holds
//               the upstream master link and the per-slave downstream arrays.
//               Modports: master (upstream master), slave (downstream
//               slaves), fabric (the interconnect itself).
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_interconnect_pipelined_if #(
  parameter int Count     = 4,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  // upstream master link
  logic [DataWidth-1:0]                 m_data_m;
  logic [AddrWidth-1:0]                 m_addr;
  logic [DataWidth/8-1:0]               m_sel;
  logic                                 m_cyc;
  logic                                 m_stb;
  logic                                 m_we;
  logic [DataWidth-1:0]                 m_data_s;
  logic                                 m_ack;
  logic                                 m_err;
  logic                                 m_stall;
  // downstream slave links, one slice per slave
  logic [Count-1:0][DataWidth-1:0]      s_data_s;
  logic [Count-1:0]                     s_ack;
  logic [Count-1:0]                     s_err;
  logic [Count-1:0]                     s_stall;
  logic [Count-1:0][DataWidth-1:0]      s_data_m;
  logic [Count-1:0][AddrWidth-1:0]      s_addr;
  logic [Count-1:0][DataWidth/8-1:0]    s_sel;
  logic [Count-1:0]                     s_cyc;
  logic [Count-1:0]                     s_stb;
  logic [Count-1:0]                     s_we;

  modport master (
    output m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
    input  m_data_s, m_ack, m_err, m_stall
  );

  modport slave (
    input  s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we,
    output s_data_s, s_ack, s_err, s_stall
  );

  modport fabric (
    input  m_data_m, m_addr, m_sel, m_cyc, m_stb, m_we,
    output m_data_s, m_ack, m_err, m_stall,
    input  s_data_s, s_ack, s_err, s_stall,
    output s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we
  );
endinterface
`default_nettype wire

// File: rtl/wb_interconnect_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : wb_interconnect_pipelined
// Description : Single-master, Count-slave Wishbone B4 pipelined interconnect
//               with base/mask address windows, an internal error slave for
//               unmapped addresses and outstanding-request tracking so that
//               responses from different slaves never interleave.
//               Optional watchdog: define WB_INTERCONNECT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_interconnect_pipelined #(
  parameter int                          Count         = 4,
  parameter int                          DataWidth     = 32,
  parameter int                          AddrWidth     = 32,
  parameter int                          MaxPending    = 4,
  parameter logic [Count-1:0][AddrWidth-1:0] SlaveBase = '0,
  parameter logic [Count-1:0][AddrWidth-1:0] SlaveMask = '0,
  parameter int                          TimeoutCycles = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  wb_interconnect_pipelined_if.fabric      bus
);

  localparam int TagW  = $clog2(Count + 1);
  localparam int PendW = $clog2(MaxPending + 1);
  localparam logic [TagW-1:0]  ErrTag  = TagW'(Count);
  localparam logic [PendW-1:0] PendMax = PendW'(MaxPending);

  logic [TagW-1:0]      tag;
  logic [TagW-1:0]      owner;
  logic [PendW-1:0]     pending;
  logic                 err_q;
  logic                 busy, active, full, conflict, accept, resp, req;
  logic                 dec_stall, own_ack, own_err, timeout_hit;
  logic [DataWidth-1:0] own_data;
  logic                 ack, err, stall;
  logic [Count-1:0]     stb_v, cyc_v;
  logic [Count-1:0][AddrWidth-1:0] addr_v;
  logic [Count-1:0][DataWidth-1:0] wdata_v;
  logic [Count-1:0][DataWidth/8-1:0] sel_v;

  // Address decode: walk downwards so the lowest matching window wins
  always_comb begin
    tag = ErrTag;
    for (int i = Count - 1; i >= 0; i--) begin
      if ((bus.m_addr & SlaveMask[i]) == (SlaveBase[i] & SlaveMask[i]))
        tag = TagW'(i);
    end
  end

  // Select stall of the decoded slave and response of the owning slave
  always_comb begin
    dec_stall = 1'b0;
    own_ack   = 1'b0;
    own_err   = 1'b0;
    own_data  = '0;
    for (int i = 0; i < Count; i++) begin
      if (tag == TagW'(i))
        dec_stall = bus.s_stall[i];
      if (owner == TagW'(i)) begin
        own_ack  = bus.s_ack[i];
        own_err  = bus.s_err[i];
        own_data = bus.s_data_s[i];
      end
    end
  end

  assign busy     = (pending != '0);
  assign active   = busy & bus.m_cyc & ~reset;
  assign req      = bus.m_cyc & bus.m_stb;
  // Responses only pass while something is outstanding; stray acks vanish
  assign ack      = active & own_ack;
  assign err      = (active & ((owner == ErrTag) ? err_q : own_err)) | timeout_hit;
  assign resp     = ack | err;
  assign full     = (pending == PendMax) & ~resp;
  assign conflict = busy & (tag != owner);
  assign stall    = reset | full | conflict | dec_stall;
  assign accept   = req & ~stall;

  assign bus.m_ack    = ack;
  assign bus.m_err    = err;
  assign bus.m_stall  = stall;
  assign bus.m_data_s = active ? own_data : '0;

  // Per-slave request fan-out; address is presented relative to its window
  always_comb begin
    stb_v   = '0;
    cyc_v   = '0;
    addr_v  = '0;
    wdata_v = '0;
    sel_v   = '0;
    for (int i = 0; i < Count; i++) begin
      stb_v[i]   = req & (tag == TagW'(i)) & ~conflict & ~full & ~reset;
      cyc_v[i]   = bus.m_cyc & ~reset & ((busy & (owner == TagW'(i))) | stb_v[i]);
      addr_v[i]  = bus.m_addr & ~SlaveMask[i];
      wdata_v[i] = bus.m_data_m;
      sel_v[i]   = bus.m_sel;
    end
  end

  assign bus.s_stb    = stb_v;
  assign bus.s_cyc    = cyc_v;
  assign bus.s_addr   = addr_v;
  assign bus.s_data_m = wdata_v;
  assign bus.s_sel    = sel_v;
  assign bus.s_we     = {Count{bus.m_we}};

`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wd;

  assign timeout_hit = active & (wd == WdW'(TimeoutCycles));

  // Watchdog: counts silent cycles while a response is owed
  always_ff @(posedge clk) begin
    if (reset || !bus.m_cyc || !busy || resp || accept)
      wd <= '0;
    else
      wd <= wd + WdW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Outstanding-request bookkeeping, owner tracking and error-slave response
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      owner   <= '0;
      err_q   <= 1'b0;
    end else if (!bus.m_cyc) begin
      pending <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept & (tag == ErrTag);
      if (accept)
        owner <= tag;
      if (timeout_hit) begin
        pending <= accept ? PendW'(1) : '0;
        if (!accept)
          owner <= '0;
      end else if (accept && !resp && pending != PendMax)
        pending <= pending + PendW'(1);
      else if (resp && !accept && busy)
        pending <= pending - PendW'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_interconnect_pipelined.md
Name: wb_interconnect_pipelined

Overview:
Single-master, Count-slave Wishbone B4 pipelined interconnect with per-slave base/mask address windows and a built-in error slave for unmapped addresses. It tracks outstanding transactions so that pipelined requests cannot interleave responses from different slaves. It sits between a core or DMA master and peripheral/memory slaves, and can be cascaded.

Parameters:
Count, 4, number of slaves (>=1)
DataWidth, 32, data bus width
AddrWidth, 32, address bus width
MaxPending, 4, maximum outstanding accepted requests (>=1)
SlaveBase, all 0, packed [Count][AddrWidth] window base per slave
SlaveMask, all 0, packed [Count][AddrWidth] window mask per slave; bits set take part in the compare
TimeoutCycles, 255, watchdog limit; used only with WB_INTERCONNECT_TIMEOUT_EN

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_data_m  in  DataWidth  master write data
m_addr  in  AddrWidth  master address
m_sel  in  DataWidth/8  byte selects
m_cyc, m_stb, m_we  in  1 each  master cycle, strobe, write enable
m_data_s  out  DataWidth  read data to master
m_ack, m_err, m_stall  out  1 each  responses to master
s_data_s  in  [Count] x DataWidth  slave read data
s_ack, s_err, s_stall  in  [Count] x 1  slave responses
s_data_m, s_addr, s_sel, s_cyc, s_stb, s_we  out  [Count] arrays  slave-side request signals

Behaviour:
- Decode (combinational on m_addr): hit[i] = ((m_addr & SlaveMask[i]) == (SlaveBase[i] & SlaveMask[i])). Lowest index wins. No hit selects the error slave, internal index Count. Tag width is $clog2(Count+1).
- s_addr[i] = m_addr & ~SlaveMask[i]. s_data_m, s_sel and s_we are broadcast to all slaves.
- State: pending counter of width $clog2(MaxPending+1), owner tag register, err_q register.
- accept = m_cyc & m_stb & ~m_stall. resp = m_ack | m_err.
- pending update:
  - +1 on accept only.
  - -1 on resp only.
  - Unchanged when accept and resp occur in the same cycle.
  - Never underflows or overflows.
- owner is loaded with the decoded tag on every accept.
- m_stall = 1 in any of these cases:
  - reset is high;
  - pending == MaxPending and there is no resp this cycle;
  - pending > 0 and decoded tag != owner (conflict; the request is held);
  - m_stall is otherwise driven by s_stall[tag] of the decoded slave. The error slave never stalls.
- s_stb[i] = m_cyc & m_stb & (tag == i) & ~conflict & ~full.
- s_cyc[i] = m_cyc & ((pending > 0 & owner == i) | s_stb[i]).
- Responses:
  - m_ack, m_err and m_data_s come from the owner slave.
  - They are forwarded only while pending > 0 and m_cyc = 1. Otherwise they are forced to 0 (stray acks are dropped).
- Error slave: an accepted unmapped request sets err_q. m_err = 1 on the next cycle for one cycle per request. m_data_s = 0 during that cycle.
- Latency: zero added cycles on the request path and on the response path for mapped slaves. One cycle for the error slave.
- m_cyc dropping to 0 clears pending and err_q on the next edge. All s_cyc go low in the same cycle.
- reset: pending = 0, err_q = 0, owner = 0. All s_cyc and s_stb = 0, m_ack = 0, m_err = 0, m_stall = 1. Reset mid-burst discards all outstanding responses.

Optional Feature:
WB_INTERCONNECT_TIMEOUT_EN
- Defined:
  - A watchdog counter increments each cycle while pending > 0 and no resp occurs. It clears on resp, on accept, or when pending == 0.
  - When the counter reaches TimeoutCycles, the block pulses m_err for one cycle, sets pending to 0 and releases owner.
  - Late slave acks are then dropped by the pending == 0 rule.
- Undefined: no watchdog logic, and a hung slave stalls the master indefinitely.

Test Plan:
- Count=2, slave0 base 0x0000_0000, slave1 base 0x1000_0000, mask 0xF000_0000. Three back-to-back reads at 0x0000_0010/14/18, slave acks at 1/cycle -> s_stb[0] high 3 cycles, 3 m_ack, s_addr = 0x10/0x14/0x18, no m_stall.
- Read 0x0000_0000 accepted, then immediately read 0x1000_0004 while slave0 ack is delayed 3 cycles -> m_stall = 1 until slave0 ack, s_stb[1] asserts the cycle after pending returns to 0.
- MaxPending=2, 3 requests to slave0 with acks withheld -> third request stalls; it is accepted in the same cycle as the first ack, and pending stays 2.
- Write to 0x5000_0000 (unmapped) -> no s_stb asserted, m_err = 1 exactly one cycle after accept, m_ack = 0.
- m_cyc deasserted with pending = 2, then slave0 asserts s_ack -> m_ack stays 0 and pending = 0. Assert reset mid-burst -> m_stall = 1 and all s_cyc = 0 during reset.
- With WB_INTERCONNECT_TIMEOUT_EN and TimeoutCycles=8: read to slave1 that never acks -> m_err pulse after 8 idle cycles, then a new request to slave0 is accepted without stall.
